// File: rtl/ibex_avalon_pkg.sv
// Shared types and constants for the Ibex req/gnt to Avalon-MM bridge.
package ibex_avalon_pkg;

    localparam logic [1:0] AVM_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AVM_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AVM_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic is_write;
        logic posted;
    } txn_entry_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AVM_RESP_OKAY;
    endfunction

endpackage

// File: rtl/ibex_avalon_txn_fifo.sv
// In-order FIFO of in-flight transactions; head is the oldest entry.
module ibex_avalon_txn_fifo
    import ibex_avalon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  txn_entry_t    push_data_i,
    input  logic          pop_i,
    output txn_entry_t    head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    txn_entry_t    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign head_o  = r_mem[r_rd_ptr];

    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ibex_avalon_bridge.sv
// Ibex req/gnt/rvalid port to Avalon-MM pipelined master with in-order completion.
// Optional response watchdog enabled by defining IBEX_AVALON_BRIDGE_TIMEOUT_EN.
module ibex_avalon_bridge
    import ibex_avalon_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int WRITE_RESP      = 1,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int BW             = DW / 8,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [BW-1:0] be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          gnt_o,
    output logic          rvalid_o,
    output logic          err_o,
    output logic [DW-1:0] rdata_o,
    output logic          avm_read_o,
    output logic          avm_write_o,
    output logic [AW-1:0] avm_address_o,
    output logic [BW-1:0] avm_byteenable_o,
    output logic [DW-1:0] avm_writedata_o,
    input  logic          avm_waitrequest_i,
    input  logic          avm_readdatavalid_i,
    input  logic [DW-1:0] avm_readdata_i,
    input  logic [1:0]    avm_response_i,
    input  logic          avm_writeresponsevalid_i,
    output logic [CW-1:0] outstanding_o,
    output logic          protocol_err_o
);

    txn_entry_t    w_head;
    txn_entry_t    w_push_data;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_can_issue;
    logic          w_pop;

    logic          r_rvalid;
    logic          r_err;
    logic [DW-1:0] r_rdata;
    logic          r_perr;

    // One-deep holding slot for a response that arrives while a posted write is at the head.
    logic          r_pend_valid;
    logic          r_pend_is_write;
    logic [1:0]    r_pend_resp;
    logic [DW-1:0] r_pend_rdata;

    logic w_in_valid;
    logic w_in_live;
    logic w_in_is_write;
    logic w_both;
    logic w_eff_valid;
    logic w_eff_is_write;
    logic [1:0]    w_eff_resp;
    logic [DW-1:0] w_eff_rdata;
    logic w_head_posted;
    logic w_eff_consumed;
    logic w_rsp_pop;
    logic w_rsp_unexp;
    logic w_mismatch;
    logic w_pend_ovf;
    logic w_timeout;

`ifdef IBEX_AVALON_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_wdog;
    logic [CW-1:0] r_orphan;
    logic          w_in_orphan;

    assign w_can_issue = ({1'b0, w_count} + {1'b0, r_orphan}) < (CW + 1)'(MAX_OUTSTANDING);
    assign w_in_orphan = w_in_valid & (r_orphan != '0);
    assign w_in_live   = w_in_valid & ~w_in_orphan;
    assign w_timeout   = ~w_empty & ~w_head_posted & ~w_eff_valid
                       & (r_wdog == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog   <= '0;
            r_orphan <= '0;
        end else begin
            if (w_pop || w_empty) begin
                r_wdog <= '0;
            end else if (!w_head_posted) begin
                r_wdog <= r_wdog + 1'b1;
            end
            case ({w_timeout, w_in_orphan})
                2'b10:   r_orphan <= r_orphan + 1'b1;
                2'b01:   r_orphan <= r_orphan - 1'b1;
                default: r_orphan <= r_orphan;
            endcase
        end
    end
`else
    assign w_can_issue = (w_count < CW'(MAX_OUTSTANDING));
    assign w_in_live   = w_in_valid;
    assign w_timeout   = 1'b0;
`endif

    assign avm_read_o       = req_i & ~we_i & w_can_issue;
    assign avm_write_o      = req_i &  we_i & w_can_issue;
    assign gnt_o            = (avm_read_o | avm_write_o) & ~avm_waitrequest_i;
    assign avm_address_o    = addr_i;
    assign avm_byteenable_o = be_i;
    assign avm_writedata_o  = wdata_i;

    assign w_push_data.is_write = we_i;
    assign w_push_data.posted   = we_i & (WRITE_RESP == 0);

    ibex_avalon_txn_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CW    (CW)
    ) u_txn_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (gnt_o),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    // Simultaneous strobes: the read wins and the write strobe is dropped.
    assign w_in_valid    = avm_readdatavalid_i | avm_writeresponsevalid_i;
    assign w_in_is_write = ~avm_readdatavalid_i;
    assign w_both        = avm_readdatavalid_i & avm_writeresponsevalid_i;

    assign w_eff_valid    = r_pend_valid | w_in_live;
    assign w_eff_is_write = r_pend_valid ? r_pend_is_write : w_in_is_write;
    assign w_eff_resp     = r_pend_valid ? r_pend_resp     : avm_response_i;
    assign w_eff_rdata    = r_pend_valid ? r_pend_rdata    : avm_readdata_i;

    assign w_head_posted  = ~w_empty & w_head.posted;
    assign w_eff_consumed = ~w_head_posted & w_eff_valid;
    assign w_rsp_pop      = w_eff_consumed & ~w_empty;
    assign w_rsp_unexp    = w_eff_consumed & w_empty;
    assign w_mismatch     = w_rsp_pop & (w_head.is_write != w_eff_is_write);
    assign w_pend_ovf     = r_pend_valid & ~w_eff_consumed & w_in_live;
    assign w_pop          = w_head_posted | w_rsp_pop | w_timeout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid        <= 1'b0;
            r_err           <= 1'b0;
            r_rdata         <= '0;
            r_perr          <= 1'b0;
            r_pend_valid    <= 1'b0;
            r_pend_is_write <= 1'b0;
            r_pend_resp     <= AVM_RESP_OKAY;
            r_pend_rdata    <= '0;
        end else begin
            r_rvalid <= w_pop;
            r_err    <= w_timeout | (w_rsp_pop & (resp_is_err(w_eff_resp) | w_mismatch));
            if (w_rsp_pop && !w_eff_is_write) begin
                r_rdata <= w_eff_rdata;
            end
            if (w_rsp_unexp || w_mismatch || w_both || w_pend_ovf) begin
                r_perr <= 1'b1;
            end
            if ((r_pend_valid && w_eff_consumed) ||
                (!r_pend_valid && w_in_live && w_head_posted)) begin
                r_pend_valid    <= w_in_live;
                r_pend_is_write <= w_in_is_write;
                r_pend_resp     <= avm_response_i;
                r_pend_rdata    <= avm_readdata_i;
            end
        end
    end

    assign rvalid_o       = r_rvalid;
    assign err_o          = r_err;
    assign rdata_o        = r_rdata;
    assign outstanding_o  = w_count;
    assign protocol_err_o = r_perr;

endmodule

// File: tb/tb_ibex_avalon_bridge.sv
// Directed bench: a cycle table on a write-response instance plus hand sequences
// for posted writes, pending responses, dual strobes and (optionally) the watchdog.
module tb_ibex_avalon_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, wt, rdv, wrv;
    logic [1:0]  resp;
    logic [31:0] rdata_in;
    logic [3:0]  be;
    logic [31:0] addr, wdata;

    logic        a_gnt, a_rv, a_err, a_rd, a_wr, a_perr;
    logic [31:0] a_rdata, a_addr, a_wdata;
    logic [3:0]  a_be;
    logic [2:0]  a_out;
    logic        p_gnt, p_rv, p_err, p_rd, p_wr, p_perr;
    logic [31:0] p_rdata, p_addr, p_wdata;
    logic [3:0]  p_be;
    logic [2:0]  p_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ibex_avalon_bridge #(.WRITE_RESP(1), .TIMEOUT_CYCLES(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(a_gnt), .rvalid_o(a_rv), .err_o(a_err), .rdata_o(a_rdata),
        .avm_read_o(a_rd), .avm_write_o(a_wr), .avm_address_o(a_addr),
        .avm_byteenable_o(a_be), .avm_writedata_o(a_wdata), .avm_waitrequest_i(wt),
        .avm_readdatavalid_i(rdv), .avm_readdata_i(rdata_in), .avm_response_i(resp),
        .avm_writeresponsevalid_i(wrv), .outstanding_o(a_out), .protocol_err_o(a_perr)
    );

    ibex_avalon_bridge #(.WRITE_RESP(0), .TIMEOUT_CYCLES(16)) dut_p (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(p_gnt), .rvalid_o(p_rv), .err_o(p_err), .rdata_o(p_rdata),
        .avm_read_o(p_rd), .avm_write_o(p_wr), .avm_address_o(p_addr),
        .avm_byteenable_o(p_be), .avm_writedata_o(p_wdata), .avm_waitrequest_i(wt),
        .avm_readdatavalid_i(rdv), .avm_readdata_i(rdata_in), .avm_response_i(resp),
        .avm_writeresponsevalid_i(wrv), .outstanding_o(p_out), .protocol_err_o(p_perr)
    );

    typedef struct {
        logic        req, we, wt, rdv, wrv;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        e_gnt, e_rd, e_wr, e_rv, e_err;
        logic [31:0] e_rdata;
        logic [2:0]  e_out;
        logic        e_perr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic v(input logic i_req, i_we, i_wt, i_rdv, i_wrv, input logic [1:0] i_resp,
                     input logic [31:0] i_rdata, input logic x_gnt, x_rd, x_wr, x_rv, x_err,
                     input logic [31:0] x_rdata, input logic [2:0] x_out, input logic x_perr);
        vec_t t;
        t.req = i_req; t.we = i_we; t.wt = i_wt; t.rdv = i_rdv; t.wrv = i_wrv;
        t.resp = i_resp; t.rdata = i_rdata;
        t.e_gnt = x_gnt; t.e_rd = x_rd; t.e_wr = x_wr; t.e_rv = x_rv; t.e_err = x_err;
        t.e_rdata = x_rdata; t.e_out = x_out; t.e_perr = x_perr;
        vecs.push_back(t);
    endtask

    // Drive at the falling edge, then settle 2ns before sampling.
    task automatic drive(input logic i_req, i_we, i_rdv, i_wrv, input logic [1:0] i_resp,
                         input logic [31:0] i_rdata);
        @(negedge clk);
        req = i_req; we = i_we; wt = 1'b0; rdv = i_rdv; wrv = i_wrv;
        resp = i_resp; rdata_in = i_rdata;
        #2;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        req = 0; we = 0; wt = 0; rdv = 0; wrv = 0; resp = 2'b00; rdata_in = '0;
        @(negedge clk);
        #2;
        chk("rst_gnt", {31'd0, a_gnt}, 32'd0);
        chk("rst_rvalid", {31'd0, a_rv | p_rv}, 32'd0);
        chk("rst_err", {31'd0, a_err | p_err}, 32'd0);
        chk("rst_perr", {31'd0, a_perr | p_perr}, 32'd0);
        chk("rst_rdata", a_rdata | p_rdata, 32'd0);
        chk("rst_out", {29'd0, a_out | p_out}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        be = 4'hA; addr = 32'h0000_1000; wdata = 32'hCAFE_0001;
        req = 0; we = 0; wt = 0; rdv = 0; wrv = 0; resp = 2'b00; rdata_in = '0;

        //   req we wt rdv wrv resp  rdata          gnt rd wr rv err rdata          out perr
        v(0, 0, 0, 0, 0, 2'b00, 32'h0,         0, 0, 0, 0, 0, 32'h0,         0, 0);
        v(1, 0, 1, 0, 0, 2'b00, 32'h0,         0, 1, 0, 0, 0, 32'h0,         0, 0);
        v(1, 0, 1, 0, 0, 2'b00, 32'h0,         0, 1, 0, 0, 0, 32'h0,         0, 0);
        v(1, 0, 1, 0, 0, 2'b00, 32'h0,         0, 1, 0, 0, 0, 32'h0,         0, 0);
        v(1, 0, 0, 0, 0, 2'b00, 32'h0,         1, 1, 0, 0, 0, 32'h0,         0, 0);
        v(0, 0, 0, 1, 0, 2'b00, 32'hDEADBEEF,  0, 0, 0, 0, 0, 32'h0,         1, 0);
        v(0, 0, 0, 0, 0, 2'b00, 32'h0,         0, 0, 0, 1, 0, 32'hDEADBEEF,  0, 0);
        v(1, 1, 0, 0, 0, 2'b00, 32'h0,         1, 0, 1, 0, 0, 32'hDEADBEEF,  0, 0);
        v(0, 0, 0, 0, 1, 2'b10, 32'h0,         0, 0, 0, 0, 0, 32'hDEADBEEF,  1, 0);
        v(0, 0, 0, 0, 0, 2'b00, 32'h0,         0, 0, 0, 1, 1, 32'hDEADBEEF,  0, 0);
        v(0, 0, 0, 0, 0, 2'b00, 32'h0,         0, 0, 0, 0, 0, 32'hDEADBEEF,  0, 0);
        v(1, 0, 0, 0, 0, 2'b00, 32'h0,         1, 1, 0, 0, 0, 32'hDEADBEEF,  0, 0);
        v(1, 0, 0, 0, 0, 2'b00, 32'h0,         1, 1, 0, 0, 0, 32'hDEADBEEF,  1, 0);
        v(1, 0, 0, 0, 0, 2'b00, 32'h0,         1, 1, 0, 0, 0, 32'hDEADBEEF,  2, 0);
        v(1, 0, 0, 0, 0, 2'b00, 32'h0,         1, 1, 0, 0, 0, 32'hDEADBEEF,  3, 0);
        v(1, 0, 0, 0, 0, 2'b00, 32'h0,         0, 0, 0, 0, 0, 32'hDEADBEEF,  4, 0);
        v(1, 0, 0, 1, 0, 2'b00, 32'h11111111,  0, 0, 0, 0, 0, 32'hDEADBEEF,  4, 0);
        v(1, 0, 0, 0, 0, 2'b00, 32'h0,         1, 1, 0, 1, 0, 32'h11111111,  3, 0);
        v(0, 0, 0, 1, 0, 2'b00, 32'h22222222,  0, 0, 0, 0, 0, 32'h11111111,  4, 0);
        v(0, 0, 0, 1, 0, 2'b11, 32'h33333333,  0, 0, 0, 1, 0, 32'h22222222,  3, 0);
        v(0, 0, 0, 1, 0, 2'b00, 32'h44444444,  0, 0, 0, 1, 1, 32'h33333333,  2, 0);
        v(0, 0, 0, 1, 0, 2'b00, 32'h55555555,  0, 0, 0, 1, 0, 32'h44444444,  1, 0);
        v(0, 0, 0, 0, 0, 2'b00, 32'h0,         0, 0, 0, 1, 0, 32'h55555555,  0, 0);
        v(0, 0, 0, 0, 0, 2'b00, 32'h0,         0, 0, 0, 0, 0, 32'h55555555,  0, 0);
        v(0, 0, 0, 1, 0, 2'b00, 32'h66666666,  0, 0, 0, 0, 0, 32'h55555555,  0, 0);
        v(0, 0, 0, 0, 0, 2'b00, 32'h0,         0, 0, 0, 0, 0, 32'h55555555,  0, 1);
        v(0, 0, 0, 0, 0, 2'b00, 32'h0,         0, 0, 0, 0, 0, 32'h55555555,  0, 1);
        v(1, 0, 0, 0, 0, 2'b00, 32'h0,         1, 1, 0, 0, 0, 32'h55555555,  0, 1);
        v(0, 0, 0, 0, 1, 2'b00, 32'h0,         0, 0, 0, 0, 0, 32'h55555555,  1, 1);
        v(0, 0, 0, 0, 0, 2'b00, 32'h0,         0, 0, 0, 1, 1, 32'h55555555,  0, 1);

        do_reset();
        chk("passthru_addr", a_addr, addr);
        chk("passthru_wdata", a_wdata, wdata);
        chk("passthru_be", {28'd0, a_be}, {28'd0, be});

        foreach (vecs[i]) begin
            @(negedge clk);
            req = vecs[i].req; we = vecs[i].we; wt = vecs[i].wt; rdv = vecs[i].rdv;
            wrv = vecs[i].wrv; resp = vecs[i].resp; rdata_in = vecs[i].rdata;
            #2;
            chk($sformatf("v%0d_gnt", i),    {31'd0, a_gnt},  {31'd0, vecs[i].e_gnt});
            chk($sformatf("v%0d_rd", i),     {31'd0, a_rd},   {31'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_wr", i),     {31'd0, a_wr},   {31'd0, vecs[i].e_wr});
            chk($sformatf("v%0d_rvalid", i), {31'd0, a_rv},   {31'd0, vecs[i].e_rv});
            chk($sformatf("v%0d_err", i),    {31'd0, a_err},  {31'd0, vecs[i].e_err});
            chk($sformatf("v%0d_rdata", i),  a_rdata,         vecs[i].e_rdata);
            chk($sformatf("v%0d_out", i),    {29'd0, a_out},  {29'd0, vecs[i].e_out});
            chk($sformatf("v%0d_perr", i),   {31'd0, a_perr}, {31'd0, vecs[i].e_perr});
        end

        // Posted writes: read, write, read completes in order on the posted instance.
        do_reset();
        drive(1, 0, 0, 0, 2'b00, 32'h0);   chk("pw_gnt0", {31'd0, p_gnt}, 32'd1);
        drive(1, 1, 0, 0, 2'b00, 32'h0);   chk("pw_gnt1", {31'd0, p_gnt}, 32'd1);
        drive(1, 0, 0, 0, 2'b00, 32'h0);   chk("pw_gnt2", {31'd0, p_gnt}, 32'd1);
        drive(0, 0, 1, 0, 2'b00, 32'hA1A1A1A1); chk("pw_out3", {29'd0, p_out}, 32'd3);
        drive(0, 0, 0, 0, 2'b00, 32'h0);
        chk("pw_rd1_rv", {31'd0, p_rv}, 32'd1);
        chk("pw_rd1_data", p_rdata, 32'hA1A1A1A1);
        drive(0, 0, 1, 0, 2'b00, 32'hA2A2A2A2);
        chk("pw_wr_rv", {31'd0, p_rv}, 32'd1);
        chk("pw_wr_err", {31'd0, p_err}, 32'd0);
        chk("pw_wr_hold", p_rdata, 32'hA1A1A1A1);
        drive(0, 0, 0, 0, 2'b00, 32'h0);
        chk("pw_rd2_rv", {31'd0, p_rv}, 32'd1);
        chk("pw_rd2_data", p_rdata, 32'hA2A2A2A2);
        drive(0, 0, 0, 0, 2'b00, 32'h0);
        chk("pw_idle_rv", {31'd0, p_rv}, 32'd0);
        chk("pw_out0", {29'd0, p_out}, 32'd0);
        chk("pw_perr", {31'd0, p_perr}, 32'd0);

        // Response arriving while a posted write is at the head is held one cycle.
        drive(1, 0, 0, 0, 2'b00, 32'h0);
        drive(1, 1, 0, 0, 2'b00, 32'h0);
        drive(1, 0, 0, 0, 2'b00, 32'h0);
        drive(0, 0, 1, 0, 2'b00, 32'hB1B1B1B1);
        drive(0, 0, 1, 0, 2'b10, 32'hB2B2B2B2);
        chk("pd_rd1_data", p_rdata, 32'hB1B1B1B1);
        drive(0, 0, 0, 0, 2'b00, 32'h0);
        chk("pd_wr_rv", {31'd0, p_rv}, 32'd1);
        chk("pd_wr_err", {31'd0, p_err}, 32'd0);
        chk("pd_wr_hold", p_rdata, 32'hB1B1B1B1);
        drive(0, 0, 0, 0, 2'b00, 32'h0);
        chk("pd_rd2_rv", {31'd0, p_rv}, 32'd1);
        chk("pd_rd2_err", {31'd0, p_err}, 32'd1);
        chk("pd_rd2_data", p_rdata, 32'hB2B2B2B2);
        chk("pd_out0", {29'd0, p_out}, 32'd0);

        // Both strobes at once: read handled, protocol error flagged.
        do_reset();
        drive(1, 0, 0, 0, 2'b00, 32'h0);
        drive(0, 0, 1, 1, 2'b00, 32'h77777777);
        drive(0, 0, 0, 0, 2'b00, 32'h0);
        chk("both_rv", {31'd0, a_rv}, 32'd1);
        chk("both_err", {31'd0, a_err}, 32'd0);
        chk("both_data", a_rdata, 32'h77777777);
        chk("both_perr", {31'd0, a_perr}, 32'd1);
        chk("both_out", {29'd0, a_out}, 32'd0);

        // Reset mid-flight: a late response afterwards counts as unexpected.
        do_reset();
        drive(1, 0, 0, 0, 2'b00, 32'h0);
        do_reset();
        drive(0, 0, 1, 0, 2'b00, 32'h88888888);
        drive(0, 0, 0, 0, 2'b00, 32'h0);
        chk("midrst_rv", {31'd0, a_rv}, 32'd0);
        chk("midrst_perr", {31'd0, a_perr}, 32'd1);

`ifdef IBEX_AVALON_BRIDGE_TIMEOUT_EN
        do_reset();
        drive(1, 0, 0, 0, 2'b00, 32'h0);
        chk("to_gnt", {31'd0, a_gnt}, 32'd1);
        for (int k = 1; k <= 16; k++) begin
            drive(0, 0, 0, 0, 2'b00, 32'h0);
            chk($sformatf("to_quiet%0d", k), {31'd0, a_rv}, 32'd0);
        end
        drive(0, 0, 0, 0, 2'b00, 32'h0);
        chk("to_rv", {31'd0, a_rv}, 32'd1);
        chk("to_err", {31'd0, a_err}, 32'd1);
        drive(0, 0, 1, 0, 2'b00, 32'h99999999);
        drive(0, 0, 0, 0, 2'b00, 32'h0);
        chk("to_late_rv", {31'd0, a_rv}, 32'd0);
        chk("to_late_perr", {31'd0, a_perr}, 32'd0);
        chk("to_late_data", a_rdata, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
